// File: rtl/glove_tracker.sv
// Per-glove conditioning: range-gated 4-sample position average, track timeout,
// closed-flag debounce and post-throw catch lockout.
module glove_tracker #(
   parameter logic [1:0]  GLOVE_ID        = 2'd1,
   parameter logic [15:0] MAX_MM          = 16'd9000,
   parameter int          DEBOUNCE_CYCLES = 270000,
   parameter int          COOLDOWN_CYCLES = 13500000,
   parameter int          TIMEOUT_CYCLES  = 2700000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] raw_x,
   input  logic [15:0] raw_y,
   input  logic        raw_valid,
   input  logic        raw_closed,
   input  logic [1:0]  ball_state,
   output logic [15:0] glove_x,
   output logic [15:0] glove_y,
   output logic        pos_valid,
   output logic        glove_closed,
   output logic        can_catch,
   output logic        track_lost
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] COOL_LD  = CW'(COOLDOWN_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

   typedef enum logic {READY, COOLDOWN} state_t;

   logic [3:0][15:0] r_bx, r_by;
   logic [17:0]      r_sx, r_sy;
   logic             r_upd;
   logic [TW-1:0]    r_tcnt;
   logic             r_s1, r_s2;
   logic [DW-1:0]    r_dcnt;
   logic [1:0]       r_prev_state;
   state_t           r_state, w_state_nx;
   logic [CW-1:0]    r_ccnt, w_ccnt_nx;
   logic             w_accept, w_release;

   assign w_accept  = raw_valid && (raw_x <= MAX_MM) && (raw_y <= MAX_MM);
   assign w_release = (r_prev_state == GLOVE_ID) && (ball_state == 2'd0);

   // A sample arriving while tracking is lost refills the whole window so the
   // average jumps straight to the new position instead of ramping from stale data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bx <= '0;
         r_by <= '0;
         r_sx <= '0;
         r_sy <= '0;
      end else if (w_accept) begin
         if (track_lost) begin
            r_bx <= {4{raw_x}};
            r_by <= {4{raw_y}};
            r_sx <= {raw_x, 2'b00};
            r_sy <= {raw_y, 2'b00};
         end else begin
            r_sx <= r_sx + {2'b00, raw_x} - {2'b00, r_bx[3]};
            r_sy <= r_sy + {2'b00, raw_y} - {2'b00, r_by[3]};
            r_bx <= {r_bx[2:0], raw_x};
            r_by <= {r_by[2:0], raw_y};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_upd     <= 1'b0;
         pos_valid <= 1'b0;
         glove_x   <= '0;
         glove_y   <= '0;
      end else begin
         r_upd     <= w_accept;
         pos_valid <= r_upd;
         if (r_upd) begin
            glove_x <= r_sx[17:2];
            glove_y <= r_sy[17:2];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tcnt     <= '0;
         track_lost <= 1'b1;
      end else if (w_accept) begin
         r_tcnt     <= '0;
         track_lost <= 1'b0;
      end else begin
         if (r_tcnt == TMO_LAST) track_lost <= 1'b1;
         if (r_tcnt != TMO_MAX)  r_tcnt     <= r_tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_dcnt       <= '0;
         glove_closed <= 1'b0;
      end else begin
         r_s1 <= raw_closed;
         r_s2 <= r_s1;
         if (r_s2 == glove_closed) begin
            r_dcnt <= '0;
         end else if (r_dcnt == DEB_MAX) begin
            glove_closed <= ~glove_closed;
            r_dcnt       <= '0;
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_state <= 2'd0;
         r_state      <= READY;
         r_ccnt       <= '0;
         can_catch    <= 1'b0;
      end else begin
         r_prev_state <= ball_state;
         r_state      <= w_state_nx;
         r_ccnt       <= w_ccnt_nx;
         can_catch    <= (r_state == READY) && !track_lost;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ccnt_nx  = r_ccnt;
      case (r_state)
         READY: begin
            if (w_release) begin
               w_state_nx = COOLDOWN;
               w_ccnt_nx  = COOL_LD;
            end
         end
         COOLDOWN: begin
            if (w_release)            w_ccnt_nx  = COOL_LD;
            else if (r_ccnt == '0)    w_state_nx = READY;
            else                      w_ccnt_nx  = r_ccnt - 1'b1;
         end
         default: w_state_nx = READY;
      endcase
   end

endmodule

// File: tb/tb_glove_tracker.sv
// Directed bench for glove_tracker: cycle-level reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_glove_tracker;
   localparam int GID = 1, DEB = 4, COOL = 10, TMO = 20, MAXV = 9000;

   logic        clk = 1'b0, reset = 1'b1;
   logic [15:0] raw_x = '0, raw_y = '0;
   logic        raw_valid = 1'b0, raw_closed = 1'b0;
   logic [1:0]  ball_state = 2'd0;
   logic [15:0] glove_x, glove_y;
   logic        pos_valid, glove_closed, can_catch, track_lost;

   int nchk = 0, nerr = 0;
   bit cmp_en = 1'b0;

   glove_tracker #(.GLOVE_ID(2'd1), .MAX_MM(16'd9000), .DEBOUNCE_CYCLES(DEB),
                   .COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .raw_x(raw_x), .raw_y(raw_y), .raw_valid(raw_valid),
      .raw_closed(raw_closed), .ball_state(ball_state), .glove_x(glove_x),
      .glove_y(glove_y), .pos_valid(pos_valid), .glove_closed(glove_closed),
      .can_catch(can_catch), .track_lost(track_lost));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: described in terms of sample history, cycles since the
   // last accept, run length of disagreeing synchronized input, and the edge of
   // the most recent release.
   int m_n = 0, m_last = 0, m_entry = -1000, m_run = 0, m_prev_ball = 0;
   int qx[$], qy[$];
   int m_px = 0, m_py = 0, m_ax = 0, m_ay = 0;
   bit m_pv = 0, m_pend = 0, m_lost = 1, m_closed = 0, m_cc = 0, m_ready = 1;
   bit m_h1 = 0, m_h2 = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_n = 0; m_last = 0; m_entry = -1000; m_run = 0; m_prev_ball = 0;
         qx.delete(); qy.delete();
         m_px = 0; m_py = 0; m_pv = 0; m_pend = 0; m_lost = 1;
         m_closed = 0; m_cc = 0; m_ready = 1; m_h1 = 0; m_h2 = 0;
      end else begin
         bit acc, rel, seen;
         m_n++;
         m_cc = m_ready && !m_lost;
         m_pv = m_pend;
         if (m_pend) begin m_px = m_ax; m_py = m_ay; end
         acc = raw_valid && (int'(raw_x) <= MAXV) && (int'(raw_y) <= MAXV);
         if (acc) begin
            if (m_lost) begin
               qx = '{int'(raw_x), int'(raw_x), int'(raw_x), int'(raw_x)};
               qy = '{int'(raw_y), int'(raw_y), int'(raw_y), int'(raw_y)};
            end else begin
               qx.push_back(int'(raw_x)); qy.push_back(int'(raw_y));
               if (qx.size() > 4) begin void'(qx.pop_front()); void'(qy.pop_front()); end
            end
            m_ax = (qx[0] + qx[1] + qx[2] + qx[3]) / 4;
            m_ay = (qy[0] + qy[1] + qy[2] + qy[3]) / 4;
            m_pend = 1; m_last = m_n; m_lost = 0;
         end else begin
            m_pend = 0;
            if (m_n - m_last >= TMO) m_lost = 1;
         end
         seen = m_h2;
         m_h2 = m_h1; m_h1 = raw_closed;
         if (seen != m_closed) m_run++; else m_run = 0;
         if (m_run == DEB + 1) begin m_closed = !m_closed; m_run = 0; end
         rel = (m_prev_ball == GID) && (ball_state == 2'd0);
         if (rel) m_entry = m_n;
         m_prev_ball = int'(ball_state);
         m_ready = (m_n - m_entry >= COOL);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("glove_x",      glove_x,      m_px);
         chk("glove_y",      glove_y,      m_py);
         chk("pos_valid",    pos_valid,    m_pv);
         chk("glove_closed", glove_closed, m_closed);
         chk("can_catch",    can_catch,    m_cc);
         chk("track_lost",   track_lost,   m_lost);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sample(input int x, input int y);
      raw_x = 16'(x); raw_y = 16'(y); raw_valid = 1'b1;
      @(negedge clk);
      raw_valid = 1'b0;
   endtask

   initial begin
      cyc(3);
      cmp_en = 1'b1;
      chk("rst_x", glove_x, 0); chk("rst_pv", pos_valid, 0);
      chk("rst_cc", can_catch, 0); chk("rst_lost", track_lost, 1);
      reset = 1'b0;
      cyc(2);

      // preload
      sample(1000, 2000);
      chk("pre_lost", track_lost, 0);
      @(negedge clk);
      chk("pre_x", glove_x, 1000); chk("pre_y", glove_y, 2000);
      chk("pre_pv", pos_valid, 1); chk("pre_cc", can_catch, 1);
      @(negedge clk);
      chk("pre_pv_drop", pos_valid, 0);

      // back-to-back averaging with truncation
      raw_y = 16'd2000; raw_valid = 1'b1;
      raw_x = 16'd1001; @(negedge clk);
      raw_x = 16'd1002; @(negedge clk);
      chk("avg1_x", glove_x, 1000);
      raw_x = 16'd1003; @(negedge clk);
      raw_valid = 1'b0;
      chk("avg2_x", glove_x, 1000);
      @(negedge clk);
      chk("avg3_x", glove_x, 1001); chk("avg3_pv", pos_valid, 1);

      // rejects
      raw_x = 16'd9001; raw_valid = 1'b1; @(negedge clk);
      raw_valid = 1'b0; @(negedge clk);
      chk("rej_pv", pos_valid, 0); chk("rej_x", glove_x, 1001);
      raw_x = 16'd9001; raw_y = 16'd100; raw_valid = 1'b1;
      cyc(21);
      raw_valid = 1'b0;
      chk("tmo_lost", track_lost, 1); chk("tmo_cc", can_catch, 0);
      sample(500, 500);
      @(negedge clk);
      chk("relock_x", glove_x, 500); chk("relock_y", glove_y, 500);
      sample(9000, 9000);
      @(negedge clk);
      chk("edge_x", glove_x, 2625);
      raw_x = 16'd100; raw_y = 16'd9001; raw_valid = 1'b1; @(negedge clk);
      raw_valid = 1'b0; @(negedge clk);
      chk("rejy_pv", pos_valid, 0);

      // debounce: short glitch, then press and release
      raw_closed = 1'b1; cyc(3); raw_closed = 1'b0; cyc(10);
      chk("glitch", glove_closed, 0);
      raw_closed = 1'b1; cyc(6);
      chk("press6", glove_closed, 0);
      cyc(1);
      chk("press7", glove_closed, 1);
      raw_closed = 1'b0; cyc(6);
      chk("rel6", glove_closed, 1);
      cyc(1);
      chk("rel7", glove_closed, 0);

      // cooldown with continuous tracking
      raw_x = 16'd500; raw_y = 16'd500; raw_valid = 1'b1;
      ball_state = 2'd1; cyc(4);
      chk("cool_pre", can_catch, 1);
      ball_state = 2'd0; cyc(1);
      chk("cool_t1", can_catch, 1);
      cyc(1);
      chk("cool_t2", can_catch, 0);
      cyc(9);
      chk("cool_t11", can_catch, 0);
      cyc(1);
      chk("cool_t12", can_catch, 1);
      ball_state = 2'd1; cyc(3);
      ball_state = 2'd0; cyc(4);
      ball_state = 2'd1; cyc(1);
      ball_state = 2'd0; cyc(1);
      cyc(10);
      chk("reld_t16", can_catch, 0);
      cyc(1);
      chk("reld_t17", can_catch, 1);
      ball_state = 2'd2; cyc(3);
      ball_state = 2'd0; cyc(5);
      chk("g2_nocool", can_catch, 1);
      raw_valid = 1'b0;

      // async reset in the middle of cooldown and debounce
      raw_closed = 1'b1; cyc(8);
      chk("held_closed", glove_closed, 1);
      ball_state = 2'd1; cyc(2);
      ball_state = 2'd0; cyc(3);
      raw_closed = 1'b0; cyc(3);
      raw_closed = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("ar_x", glove_x, 0); chk("ar_y", glove_y, 0); chk("ar_pv", pos_valid, 0);
      chk("ar_closed", glove_closed, 0); chk("ar_cc", can_catch, 0);
      chk("ar_lost", track_lost, 1);
      @(negedge clk);
      reset = 1'b0;
      cyc(6);
      chk("ar_deb6", glove_closed, 0);
      cyc(1);
      chk("ar_deb7", glove_closed, 1);
      sample(700, 900);
      @(negedge clk);
      chk("ar_pre_x", glove_x, 700); chk("ar_pre_y", glove_y, 900);
      cyc(3);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
